// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one unified memory between instruction fetch (i) and load/store (d).
// Round-robin on ties, one access in flight, one ready pulse per completed access.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    input  logic [DATA_W-1:0] mem_memData,
    output logic              busy,
    output logic              grant_id
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam int              CNT_W    = 3;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(READ_LATENCY);

    state_t           state;
    logic             lastGnt;
    logic             weReg;
    logic [CNT_W-1:0] latCnt;
    logic             winner;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        winner = 1'b0;
        if (i_req && d_req) begin
            winner = ~lastGnt;
        end else if (d_req) begin
            winner = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            lastGnt       <= 1'b1;
            weReg         <= 1'b0;
            latCnt        <= '0;
            grant_id      <= 1'b0;
            busy          <= 1'b0;
            mem_address   <= '0;
            mem_writeData <= '0;
            mem_memRead   <= 1'b0;
            mem_memWrite  <= 1'b0;
            i_rdata       <= '0;
            d_rdata       <= '0;
            i_ready       <= 1'b0;
            d_ready       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        grant_id     <= winner;
                        lastGnt      <= winner;
                        weReg        <= winner & d_we;
                        mem_address  <= winner ? d_addr : i_addr;
                        if (winner) begin
                            mem_writeData <= d_wdata;
                        end
                        mem_memWrite <= winner & d_we;
                        mem_memRead  <= ~(winner & d_we);
                        latCnt       <= '0;
                        busy         <= 1'b1;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (weReg) begin
                        mem_memWrite <= 1'b0;
                        d_ready      <= 1'b1;
                        state        <= RESP;
                    end else if (latCnt == LAT_LAST) begin
                        // memData is valid in the last read cycle; capture into the winner's register.
                        mem_memRead <= 1'b0;
                        if (grant_id) begin
                            d_rdata <= mem_memData;
                            d_ready <= 1'b1;
                        end else begin
                            i_rdata <= mem_memData;
                            i_ready <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        latCnt <= latCnt + 1'b1;
                    end
                end
                RESP: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single unified memory of the multicycle RISC-V core between two requesters: instruction fetch (port i, read-only) and load/store (port d, read/write). Serialises accesses with round-robin arbitration on ties. Drives the memory's address/writeData/memRead/memWrite and captures memData after a parameterised read latency. Returns one ready pulse per completed access.

Parameters:
ADDR_W, 32, width of all address buses; passed straight through, no alignment checks or translation.
DATA_W, 32, width of all data buses.
READ_LATENCY, 1, cycles from memRead first asserted to memData valid; legal range 0..7.

Ports:
clk  in  1  system clock, all state changes on rising edge.
reset  in  1  synchronous, active-high reset.
i_req  in  1  fetch request; held high until i_ready is seen.
i_addr  in  ADDR_W  fetch address.
i_rdata  out  DATA_W  fetched word; valid while i_ready is high, held until next fetch completes.
i_ready  out  1  one-cycle completion pulse for port i.
d_req  in  1  data request; held high until d_ready is seen.
d_we  in  1  1 = store, 0 = load.
d_addr  in  ADDR_W  load/store address.
d_wdata  in  DATA_W  store data.
d_rdata  out  DATA_W  loaded word; valid while d_ready is high, held until next load completes.
d_ready  out  1  one-cycle completion pulse for port d.
mem_address  out  ADDR_W  to memory address.
mem_writeData  out  DATA_W  to memory writeData.
mem_memRead  out  1  to memory memRead.
mem_memWrite  out  1  to memory memWrite.
mem_memData  in  DATA_W  from memory memData.
busy  out  1  high in ACCESS and RESP states.
grant_id  out  1  0 = port i, 1 = port d; current or last winner.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Request inputs are sampled only in IDLE.
- IDLE:
  - If any request is pending, pick a winner and latch its addr, wdata and we (we forced to 0 for port i).
  - Set grant_id and last_gnt to the winner, clear the latency counter, go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - A single request wins immediately.
  - If both are pending, the port other than last_gnt wins.
  - last_gnt resets to 1, so fetch wins the first tie.
- ACCESS, store: mem_memWrite = 1 for exactly one cycle, then go to RESP.
- ACCESS, load/fetch:
  - mem_memRead = 1 for READ_LATENCY+1 cycles; the counter runs 0..READ_LATENCY.
  - On the edge that ends the cycle with counter == READ_LATENCY, capture mem_memData into the winner's rdata register, then go to RESP.
- mem_memRead and mem_memWrite are 0 in every state other than ACCESS and are never high together.
- mem_address and mem_writeData come from the latched registers and hold their last value when not in ACCESS.
- RESP:
  - Winner's ready = 1 for exactly one cycle; the other ready stays 0.
  - rdata is valid during this cycle. A store leaves d_rdata unchanged.
  - Always return to IDLE.
- Handshake:
  - A requester drops req on the edge where it samples ready = 1, so req is low in the following IDLE cycle.
  - If req is still high in IDLE, it is treated as a new request.
  - Address and data may change freely once granted, because they are latched.
- Latency, with request first seen in IDLE cycle T:
  - Store: memWrite in T+1, ready in T+2.
  - Read: memRead in T+1..T+1+READ_LATENCY, ready in T+2+READ_LATENCY.
  - Back-to-back throughput: one access per 3 cycles (store) or 3+READ_LATENCY cycles (read).
- Reset (synchronous, at any point including mid-ACCESS or RESP):
  - State returns to IDLE and no ready pulse is issued for the aborted access.
  - Reset values: mem_memRead=0, mem_memWrite=0, mem_address=0, mem_writeData=0, i_ready=0, d_ready=0, i_rdata=0, d_rdata=0, busy=0, grant_id=0, last_gnt=1, counter=0.

Test Plan:
- Reset held 2 cycles with both req high -> all outputs at reset values; after release the first grant goes to port i (grant_id=0).
- Store then load: d_req, d_we=1, d_addr=3, d_wdata=200 -> memWrite high exactly one cycle with address 3 and data 200, d_ready 2 cycles after request. Then d_we=0, d_addr=3 -> d_rdata=200 with d_ready at T+3 (READ_LATENCY=1).
- Tie: i_req (addr 5) and d_req (store 10 to addr 7) raised together after reset -> port i served first, then port d; repeat with both held -> strict alternation i,d,i,d; never two readies in one cycle.
- Latency sweep READ_LATENCY=0 and 3: fetch from addr 5 holding 10 -> memRead high 1 and 4 cycles respectively; i_ready at T+2 and T+5; i_rdata=10.
- Reset asserted mid-ACCESS of a READ_LATENCY=3 load -> no d_ready, memRead low on the next edge, busy=0, d_rdata=0; a new fetch completes normally afterwards.
- Stable data: after a load returns 200, issue a fetch -> d_rdata stays 200 and i_rdata updates only at i_ready.
